// File: rtl/ram_mp_pkg.sv
// Shared types and helpers for the multi-read-port RAM (ram_mp).
// Optional build macro used by ram_mp: RAM_MP_READ_REG_EN.
package ram_mp_pkg;

  // Sweep FSM: CLEAR zeroes memory one word per cycle, IDLE is normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Memory depth for a K-bit address.
  function automatic int unsigned size_of(input int unsigned k);
    return 32'd1 << k;
  endfunction

  // Low bit of slice p in a vector packed from w-bit fields.
  function automatic int unsigned slice_lo(input int unsigned p, input int unsigned w);
    return p * w;
  endfunction

endpackage

// File: rtl/ram_mp_clear.sv
// Clear-sweep controller for ram_mp: after reset, one word per cycle is
// zeroed from address 0 up to SIZE-1, then the FSM parks in IDLE for good.
module ram_mp_clear
  import ram_mp_pkg::*;
#(
  parameter int K = 3
) (
  input  logic         clk,
  input  logic         reset,
  output state_t       state,
  output logic         busy,
  output logic         clr_we,
  output logic [K-1:0] clr_addr
);

  logic [K-1:0] ptr;

  // FSM and sweep pointer; busy is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          // Terminal compare on the last word; the pointer is never reused.
          if (ptr == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          state <= IDLE;
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // The reset edge itself never writes; the sweep starts on the next edge.
  assign clr_we   = (state == CLEAR) && !reset;
  assign clr_addr = ptr;

endmodule

// File: rtl/ram_mp.sv
// Multi-read-port RAM: one write port (address slice 0), PORTS independent
// read ports, contents cleared by a sweep after synchronous reset.
// Build macro RAM_MP_READ_REG_EN: registered reads with write-first bypass
// (1-cycle latency); undefined gives combinational reads.
module ram_mp
  import ram_mp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 3,
  parameter int PORTS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [WIDTH-1:0]       in,
  input  logic [PORTS*K-1:0]     address,
  output logic [PORTS*WIDTH-1:0] out,
  output logic                   busy
);

  localparam int SIZE = size_of(K);

  logic [WIDTH-1:0] mem [SIZE];
  state_t           state;
  logic             clr_we;
  logic [K-1:0]     clr_addr;
  logic [K-1:0]     addr0;
  logic             wr_en;

  ram_mp_clear #(.K(K)) u_clear (
    .clk      (clk),
    .reset    (reset),
    .state    (state),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign addr0 = address[K-1:0];
  // User writes only in IDLE; a simultaneous reset always wins.
  assign wr_en = load && (state == IDLE) && !reset;

  // Single write port shared between the clear sweep and the user.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      mem[addr0] <= in;
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [K-1:0]     addr;
    logic [WIDTH-1:0] rd;

    assign addr = address[slice_lo(p, K) +: K];
    assign out[slice_lo(p, WIDTH) +: WIDTH] = rd;

`ifdef RAM_MP_READ_REG_EN
    // Registered read; a same-edge write to this address is forwarded.
    always_ff @(posedge clk) begin
      if (reset || busy) begin
        rd <= '0;
      end else if (wr_en && (addr == addr0)) begin
        rd <= in;
      end else begin
        rd <= mem[addr];
      end
    end
`else
    // Combinational read, held at zero while the sweep is running.
    always_comb begin
      rd = '0;
      if (!busy) begin
        rd = mem[addr];
      end
    end
`endif
  end

endmodule

// File: tb/tb_ram_mp.sv
// Self-checking bench for ram_mp (WIDTH=16, K=3, PORTS=2).
module tb_ram_mp;

  localparam int WIDTH = 16;
  localparam int K     = 3;
  localparam int PORTS = 2;
  localparam int SIZE  = 8;

  logic                   clk;
  logic                   reset;
  logic                   load;
  logic [WIDTH-1:0]       in;
  logic [PORTS*K-1:0]     address;
  logic [PORTS*WIDTH-1:0] out;
  logic                   busy;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_mem [SIZE];
  logic [WIDTH-1:0] exp_v;
  int               errors;
  int               checks;

  ram_mp #(.WIDTH(WIDTH), .K(K), .PORTS(PORTS)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .in      (in),
    .address (address),
    .out     (out),
    .busy    (busy)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int a0, input int a1);
    address = {3'(a1), 3'(a0)};
  endtask

  task automatic clear_model();
    for (int i = 0; i < SIZE; i++) model_mem[i] = '0;
  endtask

  // Waits for busy to fall (bounded) and returns the number of edges taken.
  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    load  = 1'b0;
    in    = '0;
    set_addr(0, 0);
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b want=1", busy); end
    checks++;
    if (out !== '0) begin errors++; $display("FAIL reset_out got=%h want=0", out); end
    reset = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
      checks++;
      if (out !== '0) begin errors++; $display("FAIL sweep_out cyc=%0d got=%h want=0", n, out); end
    end
    checks++;
    if (n !== SIZE) begin errors++; $display("FAIL sweep_len got=%0d want=%0d", n, SIZE); end
    clear_model();
    for (int a = 0; a < SIZE; a++) begin
      set_addr(a, SIZE - 1 - a);
      exp_q.push_back(model_mem[a]);
      exp_q.push_back(model_mem[SIZE - 1 - a]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (out[15:0] !== exp_v) begin errors++; $display("FAIL clear_rd0 a=%0d got=%h want=%h", a, out[15:0], exp_v); end
      exp_v = exp_q.pop_front();
      checks++;
      if (out[31:16] !== exp_v) begin errors++; $display("FAIL clear_rd1 a=%0d got=%h want=%h", a, out[31:16], exp_v); end
    end
  endtask

`ifndef RAM_MP_READ_REG_EN
  task automatic test_fill();
    for (int i = 0; i < SIZE; i++) begin
      set_addr(i, (i + SIZE - 1) % SIZE);
      in   = 16'(i);
      load = 1'b1;
      model_mem[i] = 16'(i);
      exp_q.push_back(16'(i));
      exp_q.push_back(model_mem[(i + SIZE - 1) % SIZE]);
      tick();
      load = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if (out[15:0] !== exp_v) begin errors++; $display("FAIL fill_out0 i=%0d got=%h want=%h", i, out[15:0], exp_v); end
      exp_v = exp_q.pop_front();
      checks++;
      if (out[31:16] !== exp_v) begin errors++; $display("FAIL fill_out1 i=%0d got=%h want=%h", i, out[31:16], exp_v); end
    end
  endtask

  task automatic test_streaming();
    load = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      set_addr(i, (i + 1) % SIZE);
      in = 16'(i + 16'h100);
      exp_q.push_back(model_mem[(i + 1) % SIZE]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (out[31:16] !== exp_v) begin errors++; $display("FAIL stream_old1 i=%0d got=%h want=%h", i, out[31:16], exp_v); end
      model_mem[i] = 16'(i + 16'h100);
      exp_q.push_back(model_mem[i]);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (out[15:0] !== exp_v) begin errors++; $display("FAIL stream_out0 i=%0d got=%h want=%h", i, out[15:0], exp_v); end
    end
    load = 1'b0;
    // Both ports on one address see the same word.
    for (int a = 2; a < SIZE; a += 3) begin
      set_addr(a, a);
      exp_q.push_back(model_mem[a]);
      exp_q.push_back(model_mem[a]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (out[15:0] !== exp_v) begin errors++; $display("FAIL same_addr0 a=%0d got=%h want=%h", a, out[15:0], exp_v); end
      exp_v = exp_q.pop_front();
      checks++;
      if (out[31:16] !== exp_v) begin errors++; $display("FAIL same_addr1 a=%0d got=%h want=%h", a, out[31:16], exp_v); end
    end
  endtask

  task automatic test_load_during_clear();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load  = 1'b1;
    in    = 16'hBEEF;
    set_addr(3, 3);
    clear_model();
    wait_sweep(n);
    checks++;
    if (n !== SIZE) begin errors++; $display("FAIL ldclr_len got=%0d want=%0d", n, SIZE); end
    // Load still high: nothing may have been written during the sweep.
    exp_q.push_back(model_mem[3]);
    exp_v = exp_q.pop_front();
    checks++;
    if (out[15:0] !== exp_v) begin errors++; $display("FAIL ldclr_rd got=%h want=%h", out[15:0], exp_v); end
    // First IDLE edge accepts the held write.
    model_mem[3] = 16'hBEEF;
    exp_q.push_back(model_mem[3]);
    tick();
    load = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (out[31:16] !== exp_v) begin errors++; $display("FAIL ldclr_first got=%h want=%h", out[31:16], exp_v); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    set_addr(6, 6);
    in   = 16'h00AA;
    load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (out[15:0] !== 16'h00AA) begin errors++; $display("FAIL mid_pre got=%h want=00aa", out[15:0]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b want=1", busy); end
    reset = 1'b0;
    clear_model();
    wait_sweep(n);
    checks++;
    if (n !== SIZE) begin errors++; $display("FAIL mid_len got=%0d want=%0d", n, SIZE); end
    exp_q.push_back(model_mem[6]);
    exp_v = exp_q.pop_front();
    checks++;
    if (out[15:0] !== exp_v) begin errors++; $display("FAIL mid_rd6 got=%h want=%h", out[15:0], exp_v); end
  endtask
`else
  task automatic test_read_reg();
    set_addr(5, 5);
    in   = 16'h1234;
    load = 1'b1;
    exp_q.push_back(16'h1234);
    tick();
    load = 1'b0;
    model_mem[5] = 16'h1234;
    exp_v = exp_q.pop_front();
    checks++;
    if (out[31:16] !== exp_v) begin errors++; $display("FAIL rreg_bypass got=%h want=%h", out[31:16], exp_v); end
    set_addr(5, 2);
    #1;
    checks++;
    if (out[31:16] !== 16'h1234) begin errors++; $display("FAIL rreg_hold got=%h want=1234", out[31:16]); end
    exp_q.push_back(model_mem[2]);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (out[31:16] !== exp_v) begin errors++; $display("FAIL rreg_next got=%h want=%h", out[31:16], exp_v); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
`ifndef RAM_MP_READ_REG_EN
    test_fill();
    test_streaming();
    test_load_during_clear();
    test_reset_mid_sweep();
`else
    test_read_reg();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
